// File: rtl/mem_arbiter_pkg.sv
// arm_mem_pkg: shared arbiter state type, bus width defaults and the error read pattern.
package arm_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  typedef enum logic [2:0] {IDLE, D_WAIT, I_WAIT, D_DONE, I_DONE} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_if: IF/MEM requester ports, SRAM handshake and freeze/error status of the arbiter.
interface mem_arb_if import arm_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ack;
  logic              freeze;
  logic              bus_err;
  modport master (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata, sram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, sram_req, sram_we, sram_addr, sram_wdata,
           freeze, bus_err
  );
  modport slave (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata, sram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, sram_req, sram_we, sram_addr, sram_wdata,
           freeze, bus_err
  );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// mem_arb_watchdog: counts SRAM wait cycles and flags expiry when no ack arrives in time.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst || start) cnt <= '0;
    else if (active && !ack) cnt <= cnt + 1'b1;
  end
  assign expired = active && !ack && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port SRAM between IF and MEM (data first) and drives pipeline freeze.
// Optional macro MEM_ARB_TIMEOUT_EN adds a wait watchdog that aborts with ERR_DATA and sticky bus_err.
module mem_arbiter import arm_mem_pkg::*; #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  arb_state_t        state;
  logic              data_req, expired;
  logic              req_q, we_q, if_ready_q, mem_ready_q, bus_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, mem_rdata_q;
  assign data_req = bus.mem_rd_en | bus.mem_wr_en;
`ifdef MEM_ARB_TIMEOUT_EN
  logic waiting;
  assign waiting = state == D_WAIT || state == I_WAIT;
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .start   (state == IDLE && (data_req || bus.if_req)),
    .active  (waiting),
    .ack     (bus.sram_ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            state   <= D_WAIT;
            req_q   <= 1'b1;
            we_q    <= bus.mem_wr_en;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
          end else if (bus.if_req) begin
            state  <= I_WAIT;
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= bus.if_addr;
          end
        end
        D_WAIT, I_WAIT: begin
          // a real ack always beats a coincident expiry
          if (bus.sram_ack || expired) begin
            state       <= state == D_WAIT ? D_DONE : I_DONE;
            req_q       <= 1'b0;
            mem_ready_q <= state == D_WAIT;
            if_ready_q  <= state == I_WAIT;
            bus_err_q   <= bus_err_q | ~bus.sram_ack;
            if (state == I_WAIT) if_rdata_q <= bus.sram_ack ? bus.sram_rdata : DATA_W'(ERR_DATA);
            else if (!we_q || !bus.sram_ack) mem_rdata_q <= bus.sram_ack ? bus.sram_rdata : DATA_W'(ERR_DATA);
          end
        end
        default: begin
          state       <= IDLE;
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.sram_req   = req_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.freeze     = (data_req & ~mem_ready_q) | (bus.if_req & ~if_ready_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
  import arm_mem_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  mem_arb_if bus();
  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int SLOW = 3;
`else
  localparam int SLOW = 5;
`endif
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic clear_in();
    bus.if_req = 0; bus.if_addr = '0; bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.sram_ack = 0; bus.sram_rdata = '0;
  endtask
  typedef struct {
    logic rd, wr, ireq;
    logic [31:0] maddr, iaddr, wdata, rdata;
    int delay;
    logic exp_we;
    logic [31:0] exp_addr;
    logic exp_d;
    int exp_lat;
    logic [31:0] exp_mr, exp_ir;
  } vec_t;
  vec_t vt[6];
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, seen, cnt;
    bit done;
    logic [7:0] exp_req, exp_rdy;
    vt[0] = '{1,0,0, 32'h20, 0, 0, 32'h1111_0000, 1, 0, 32'h20, 1, 2, 32'h1111_0000, 32'hBBBB_0002};
    vt[1] = '{0,0,1, 0, 32'h24, 0, 32'h2222_0000, 2, 0, 32'h24, 0, 3, 32'h1111_0000, 32'h2222_0000};
    vt[2] = '{0,1,0, 32'h200, 0, 32'hCAFE_F00D, 32'h3333_0000, SLOW, 1, 32'h200, 1, SLOW + 1, 32'h1111_0000, 32'h2222_0000};
    vt[3] = '{1,1,1, 32'h204, 32'h28, 32'h5555_AAAA, 32'h4444_0000, 1, 1, 32'h204, 1, 2, 32'h1111_0000, 32'h2222_0000};
    vt[4] = '{1,0,1, 32'h30, 32'h34, 0, 32'h5555_0000, 4, 0, 32'h30, 1, 5, 32'h5555_0000, 32'h2222_0000};
    vt[5] = '{0,0,1, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFC, 0, 2, 32'h5555_0000, 32'hFFFF_FFFF};
    // reset held with a pending fetch, then a 1-cycle-ack fetch
    clear_in();
    bus.if_req = 1; bus.if_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("rst_sram_req", bus.sram_req, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_freeze", bus.freeze, 1);
    rst = 1;
    @(negedge clk);
    chk("t1_sram_req", bus.sram_req, 1);
    chk("t1_sram_addr", bus.sram_addr, 32'h10);
    chk("t1_sram_we", bus.sram_we, 0);
    bus.sram_ack = 1; bus.sram_rdata = 32'hE3A0_1005;
    @(negedge clk);
    bus.sram_ack = 0;
    chk("t1_if_ready", bus.if_ready, 1);
    chk("t1_if_rdata", bus.if_rdata, 32'hE3A0_1005);
    bus.if_req = 0;
    @(negedge clk);
    chk("t1_if_ready_pulse", bus.if_ready, 0);
    chk("t1_if_rdata_hold", bus.if_rdata, 32'hE3A0_1005);
    // simultaneous requests: data first, fetch after DONE and IDLE
    bus.mem_rd_en = 1; bus.mem_addr = 32'h100; bus.if_req = 1; bus.if_addr = 32'h14;
    exp_req = 8'b0000_1001;
    exp_rdy = 8'b0001_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.sram_ack = 0;
      chk($sformatf("t2_sram_req_%0d", i), bus.sram_req, exp_req[i]);
      chk($sformatf("t2_freeze_%0d", i), bus.freeze, i == 4 ? 1'b0 : 1'b1);
      chk($sformatf("t2_ready_%0d", i), bus.mem_ready | bus.if_ready, exp_rdy[i]);
      if (i == 0) begin
        chk("t2_data_addr", bus.sram_addr, 32'h100);
        bus.sram_ack = 1; bus.sram_rdata = 32'hAAAA_0001;
      end
      if (i == 1) begin
        chk("t2_mem_ready", bus.mem_ready, 1);
        chk("t2_mem_rdata", bus.mem_rdata, 32'hAAAA_0001);
        bus.mem_rd_en = 0;
      end
      if (i == 3) begin
        chk("t2_if_addr", bus.sram_addr, 32'h14);
        bus.sram_ack = 1; bus.sram_rdata = 32'hBBBB_0002;
      end
      if (i == 4) begin
        chk("t2_if_rdata", bus.if_rdata, 32'hBBBB_0002);
        bus.if_req = 0;
      end
    end
    @(negedge clk);
    // table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      bus.mem_rd_en = vt[v].rd; bus.mem_wr_en = vt[v].wr; bus.if_req = vt[v].ireq;
      bus.mem_addr = vt[v].maddr; bus.if_addr = vt[v].iaddr; bus.mem_wdata = vt[v].wdata;
      lat = 0; seen = 0; done = 0;
      while (!done && lat < 40) begin
        @(negedge clk);
        lat++;
        bus.sram_ack = 0;
        if (bus.mem_ready || bus.if_ready) begin
          done = 1;
          chk($sformatf("v%0d_mem_ready", v), bus.mem_ready, vt[v].exp_d);
          chk($sformatf("v%0d_if_ready", v), bus.if_ready, !vt[v].exp_d);
          chk($sformatf("v%0d_latency", v), lat, vt[v].exp_lat);
          chk($sformatf("v%0d_mem_rdata", v), bus.mem_rdata, vt[v].exp_mr);
          chk($sformatf("v%0d_if_rdata", v), bus.if_rdata, vt[v].exp_ir);
          chk($sformatf("v%0d_req_low", v), bus.sram_req, 0);
        end else if (bus.sram_req) begin
          seen++;
          chk($sformatf("v%0d_we", v), bus.sram_we, vt[v].exp_we);
          chk($sformatf("v%0d_addr", v), bus.sram_addr, vt[v].exp_addr);
          if (vt[v].exp_we) chk($sformatf("v%0d_wdata", v), bus.sram_wdata, vt[v].wdata);
          if (seen == vt[v].delay) begin
            bus.sram_ack = 1; bus.sram_rdata = vt[v].rdata;
          end
        end
      end
      if (!done) chk($sformatf("v%0d_ready_seen", v), 0, 1);
      clear_in();
      @(negedge clk);
    end
    // held load after ready is re-granted only after IDLE
    bus.mem_rd_en = 1; bus.mem_addr = 32'h300;
    exp_req = 8'b0100_1001;
    exp_rdy = 8'b1001_0010;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t4_req_%0d", i), bus.sram_req, exp_req[i]);
      chk($sformatf("t4_rdy_%0d", i), bus.mem_ready, exp_rdy[i]);
      cnt += int'(bus.sram_req);
      bus.sram_ack = bus.sram_req; bus.sram_rdata = 32'h7777_0000;
    end
    chk("t4_accesses", cnt, 3);
    chk("t4_mem_rdata", bus.mem_rdata, 32'h7777_0000);
    clear_in();
    @(negedge clk);
    // randomized run against a transaction-level model
    begin
      bit busy = 0, ack_pend = 0, m_d = 0, m_we = 0, mrdy, irdy, dreq;
      int free_at = 0, wait_n = 0, k;
      logic [31:0] m_addr = '0, m_wdata = '0, exp_mr = 32'h7777_0000, exp_ir = 32'hFFFF_FFFF;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        mrdy = 0; irdy = 0;
        if (busy && ack_pend) begin
          busy = 0; free_at = cyc + 2;
          if (m_d) begin
            mrdy = 1;
            if (m_we) mem[m_addr] = m_wdata;
            else exp_mr = rd_mem(m_addr);
          end else begin
            irdy = 1; exp_ir = rd_mem(m_addr);
          end
        end
        ack_pend = 0;
        dreq = bus.mem_rd_en | bus.mem_wr_en;
        if (!busy && cyc >= free_at && (dreq || bus.if_req)) begin
          busy = 1; wait_n = 0; m_d = dreq;
          m_we = dreq & bus.mem_wr_en;
          m_addr = dreq ? bus.mem_addr : bus.if_addr;
          m_wdata = bus.mem_wdata;
        end
        chk("rnd_sram_req", bus.sram_req, busy);
        if (busy) begin
          chk("rnd_sram_addr", bus.sram_addr, m_addr);
          chk("rnd_sram_we", bus.sram_we, m_we);
          if (m_we) chk("rnd_sram_wdata", bus.sram_wdata, m_wdata);
        end
        chk("rnd_mem_ready", bus.mem_ready, mrdy);
        chk("rnd_if_ready", bus.if_ready, irdy);
        chk("rnd_mem_rdata", bus.mem_rdata, exp_mr);
        chk("rnd_if_rdata", bus.if_rdata, exp_ir);
        bus.sram_ack = 0;
        if (busy) begin
          wait_n++;
          if (wait_n == 3 || $urandom_range(2) == 0) begin
            bus.sram_ack = 1; bus.sram_rdata = rd_mem(bus.sram_addr); ack_pend = 1;
          end
        end else if ($urandom_range(7) == 0) begin
          bus.sram_ack = 1; bus.sram_rdata = $urandom;
        end
        if (mrdy || !dreq || $urandom_range(31) == 0) begin
          k = $urandom_range(5);
          bus.mem_rd_en = k == 3 || k == 5;
          bus.mem_wr_en = k == 4 || k == 5;
          bus.mem_addr = 32'($urandom_range(7)) << 2;
          bus.mem_wdata = $urandom;
        end
        if (irdy || !bus.if_req || $urandom_range(31) == 0) begin
          bus.if_req = 1'($urandom_range(1));
          bus.if_addr = 32'($urandom_range(7)) << 2;
        end
        #1;
        chk("rnd_freeze", bus.freeze,
            ((bus.mem_rd_en | bus.mem_wr_en) & ~mrdy) | (bus.if_req & ~irdy));
      end
    end
    clear_in();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    // reset during D_WAIT, late ack afterwards
    bus.mem_rd_en = 1; bus.mem_addr = 32'h400;
    @(negedge clk);
    chk("t5_in_wait", bus.sram_req, 1);
    rst = 0;
    @(negedge clk);
    chk("t5_req_cleared", bus.sram_req, 0);
    chk("t5_no_ready", bus.mem_ready, 0);
    rst = 1; bus.mem_rd_en = 0; bus.sram_ack = 1; bus.sram_rdata = 32'h9999_0000;
    @(negedge clk);
    bus.sram_ack = 0;
    chk("t5_late_ack_ready", bus.mem_ready, 0);
    chk("t5_late_ack_req", bus.sram_req, 0);
    chk("t5_mem_rdata", bus.mem_rdata, 0);
    @(negedge clk);
    chk("t5_still_idle", bus.mem_ready, 0);
`ifdef MEM_ARB_TIMEOUT_EN
    bus.mem_rd_en = 1; bus.mem_addr = 32'h500;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_wait_%0d", i), bus.sram_req, 1);
      chk($sformatf("t6_noready_%0d", i), bus.mem_ready, 0);
    end
    @(negedge clk);
    chk("t6_to_ready", bus.mem_ready, 1);
    chk("t6_to_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("t6_to_bus_err", bus.bus_err, 1);
    chk("t6_to_req_low", bus.sram_req, 0);
    bus.mem_rd_en = 0;
    repeat (2) @(negedge clk);
    chk("t6_bus_err_sticky", bus.bus_err, 1);
    chk("t6_ready_pulse", bus.mem_ready, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    chk("t6_bus_err_reset", bus.bus_err, 0);
    @(negedge clk);
    bus.mem_rd_en = 1; bus.mem_addr = 32'h504;
    repeat (4) @(negedge clk);
    chk("t6_ack4_req", bus.sram_req, 1);
    bus.sram_ack = 1; bus.sram_rdata = 32'h600D_DA7A;
    @(negedge clk);
    bus.sram_ack = 0; bus.mem_rd_en = 0;
    chk("t6_ack4_ready", bus.mem_ready, 1);
    chk("t6_ack4_rdata", bus.mem_rdata, 32'h600D_DA7A);
    chk("t6_ack4_bus_err", bus.bus_err, 0);
`else
    bus.mem_rd_en = 1; bus.mem_addr = 32'h500;
    repeat (9) @(negedge clk);
    chk("t6_unbounded_req", bus.sram_req, 1);
    chk("t6_unbounded_ready", bus.mem_ready, 0);
    chk("t6_unbounded_bus_err", bus.bus_err, 0);
    bus.sram_ack = 1; bus.sram_rdata = 32'h600D_DA7A;
    @(negedge clk);
    bus.sram_ack = 0; bus.mem_rd_en = 0;
    chk("t6_unbounded_done", bus.mem_ready, 1);
    chk("t6_unbounded_rdata", bus.mem_rdata, 32'h600D_DA7A);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port program/data SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences each access with a request/ack handshake to the SRAM.
- Drives the pipeline-wide freeze while any requester is waiting.
- Sits beside the five-stage ARM core: IF_stage and MEM_Stage connect to it, and its freeze replaces the constant freeze in the core top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, maximum SRAM wait cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on the rising edge of clk; 0 = reset)
- if_req  in  1  instruction fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- mem_rd_en  in  1  data load request; held until mem_ready
- mem_wr_en  in  1  data store request; held until mem_ready
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid when mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for MEM
- sram_req  out  1  SRAM access strobe; held until sram_ack
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data; valid with sram_ack
- sram_ack  in  1  SRAM completion, one cycle
- freeze  out  1  pipeline stall
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0 at edge): state IDLE. sram_req, sram_we, if_ready, mem_ready, bus_err = 0. sram_addr, sram_wdata, if_rdata, mem_rdata = 0.
- States: IDLE, D_WAIT, I_WAIT, D_DONE, I_DONE.
- data_req = mem_rd_en | mem_wr_en. If mem_rd_en and mem_wr_en are both 1, treat as a write.
- IDLE:
  - data_req=1 → D_WAIT. Latch mem_addr, mem_wdata and mem_wr_en into sram_addr, sram_wdata and sram_we.
  - else if_req=1 → I_WAIT. Latch if_addr; sram_we=0.
  - else stay in IDLE.
  - Fixed priority: data wins on simultaneous requests, because MEM is older in program order.
- D_WAIT / I_WAIT:
  - sram_req=1. Address, data and we are held stable.
  - sram_ack=1 → D_DONE / I_DONE. Capture sram_rdata into mem_rdata / if_rdata; writes leave mem_rdata unchanged.
  - sram_ack=0 → stay in the wait state.
- D_DONE / I_DONE:
  - sram_req=0. mem_ready / if_ready = 1 for exactly this cycle.
  - Always → IDLE. Requests are ignored in DONE, so a still-held request is never served twice.
- Latency: request seen in IDLE at cycle t; sram_req from t+1; ack at t+k (k≥1); ready at t+k+1; next grant evaluated at t+k+2. Minimum request-to-ready latency is 2 cycles.
- A waiting IF is served on the first IDLE in which data_req=0.
- freeze (combinational) = (data_req & ~mem_ready) | (if_req & ~if_ready).
- sram_ack in IDLE or DONE is ignored.
- A request dropped mid-wait (e.g. flush) does not abort the transaction. The ready pulse still fires and the requester discards it.
- Reset mid-transaction: IDLE at the next edge, sram_req=0, and a late ack is ignored.
- if_rdata and mem_rdata hold their values between transactions.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entry to D_WAIT / I_WAIT and increments each wait cycle.
  - If the count reaches TIMEOUT_CYCLES with no ack: go to the DONE state, pulse ready with rdata = 32'hDEAD_BEEF, and set bus_err=1 (sticky until reset).
  - An ack in the same cycle as the timeout takes precedence and is treated as normal completion.
- Without the macro: waits are unbounded, no counter exists, and bus_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package arm_mem_pkg:
  - arbiter state enum, 3-bit encoding
  - ADDR_W / DATA_W defaults
  - ERR_DATA constant 32'hDEAD_BEEF
- Sub-module mem_arb_watchdog: counter plus compare, with inputs start/active/ack and output expired. Instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
1. Reset held 3 cycles with if_req=1 → sram_req=0, if_ready=0, bus_err=0. After release, if_addr=0x10 with ack 1 cycle after sram_req and sram_rdata=0xE3A01005 → if_ready pulse at t+2, if_rdata=0xE3A01005.
2. if_req and mem_rd_en both asserted at t (mem_addr=0x100, IF addr 0x14) → data served first and mem_ready at t+2. IF sram_req starts at t+3, if_ready at t+4. freeze stays high from t through t+3 and drops at t+4.
3. Store mem_wr_en, addr=0x200, wdata=0xCAFEF00D, ack delayed 5 cycles → sram_we=1 with address and data stable all 5 cycles, single mem_ready pulse, mem_rdata unchanged.
4. Hold mem_rd_en after mem_ready → exactly one SRAM access per request (the DONE state blocks re-grant). A second access starts only after IDLE.
5. Pulse rst=0 during D_WAIT, then ack arrives after reset → state IDLE, no ready pulse, ack ignored.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_ready after the 4th wait cycle, mem_rdata=0xDEADBEEF, bus_err=1 and held. Ack coinciding with the 4th cycle → normal data, bus_err=0.
